// File: rtl/operand_engine.sv
// operand_engine: iterative compute responder on the loader's start/done handshake.
// Captures four operands on a rising start, then bit-serially computes
//   g = popcount(a) + popcount(b)
//   h = floor(log_c(d)), or all-ones when c < 2
// and holds done high until start is released.
//
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   a, b  - popcount operands
//   c     - log base
//   d     - log argument
//   start - level request from the loader
//   g, h  - registered results, valid while done = 1
//   done  - results valid, held until start is low
//   busy  - high while computing (POP or LOG)
module operand_engine #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic             done,
  output logic             busy
);

  localparam int unsigned KW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StPop, StLog, StDone} state_e;

  state_e             state_q, state_d;
  logic               start_q;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [KW-1:0]      k_q, k_d;
  logic [WIDTH-1:0]   g_q, g_d;
  logic [WIDTH-1:0]   h_q, h_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               rise;
  logic [2*WIDTH-1:0] t;

  assign rise = start & ~start_q;
  // Full-width product; p <= d keeps p itself within WIDTH bits.
  assign t    = (2*WIDTH)'(p_q) * (2*WIDTH)'(c_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      c_q     <= '0;
      d_q     <= '0;
      p_q     <= WIDTH'(1);
      k_q     <= '0;
      g_q     <= '0;
      h_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      c_q     <= c_d;
      d_q     <= d_d;
      p_q     <= p_d;
      k_q     <= k_d;
      g_q     <= g_d;
      h_q     <= h_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    c_d     = c_q;
    d_d     = d_q;
    p_d     = p_q;
    k_d     = k_q;
    g_d     = g_q;
    h_d     = h_q;

    case (state_q)
      StIdle: begin
        if (rise) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = c;
          d_d     = d;
          g_d     = '0;
          h_d     = '0;
          k_d     = '0;
          p_d     = WIDTH'(1);
          state_d = StPop;
        end
      end
      StPop: begin
        g_d    = g_q + WIDTH'(a_sh_q[0]) + WIDTH'(b_sh_q[0]);
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        k_d    = k_q + 1'b1;
        if (k_q == KW'(WIDTH - 1)) begin
          state_d = StLog;
        end
      end
      StLog: begin
        if (c_q < WIDTH'(2)) begin
          h_d     = '1;
          state_d = StDone;
        end else if (t <= (2*WIDTH)'(d_q)) begin
          p_d = t[WIDTH-1:0];
          h_d = h_q + 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d == StPop) || (state_d == StLog);
    done_d = (state_d == StDone);
  end

  assign g    = g_q;
  assign h    = h_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_operand_engine.sv
// Self-checking bench for operand_engine (WIDTH = 16).
// A behavioural model derives g, h and latency from the operands; a compare
// process checks g/h/busy on every cycle done is high, and directed sequences
// check reset, latency, handshake and ignored-rise behaviour.
module tb_operand_engine;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] a, b, c, d;
  logic         start;
  logic [W-1:0] g, h;
  logic         done, busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_g = '0;
  logic [W-1:0] exp_h = '0;

  operand_engine #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .start (start),
    .g     (g),
    .h     (h),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Model: plain arithmetic over the operand values.
  function automatic int model_g(input int unsigned av, input int unsigned bv);
    return $countones(av) + $countones(bv);
  endfunction

  function automatic int model_h(input longint cv, input longint dv);
    longint p;
    int     n;
    if (cv < 2) return (1 << W) - 1;
    p = 1;
    n = 0;
    while (p * cv <= dv) begin
      p = p * cv;
      n++;
    end
    return n;
  endfunction

  function automatic int model_lat(input longint cv, input longint dv);
    return (cv < 2) ? W + 1 : W + 1 + model_h(cv, dv);
  endfunction

  // Results must be stable and correct whenever done is high.
  always @(negedge clk) begin
    if (!rst && done) begin
      check(g == exp_g, "cmp_g", g, exp_g);
      check(h == exp_h, "cmp_h", h, exp_h);
      check(busy == 1'b0, "cmp_busy_in_done", busy, 0);
    end
  end

  // Drive operands and raise start at a negedge; pins the model to hand values.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] cv,
                        input logic [W-1:0] dv, input int lit_g, input int lit_h,
                        input int lit_lat, input string name);
    a = av; b = bv; c = cv; d = dv;
    start = 1'b1;
    exp_g = W'(model_g(av, bv));
    exp_h = W'(model_h(cv, dv));
    check(int'(exp_g) == lit_g, {name, " model_g"}, exp_g, lit_g);
    check(int'(exp_h) == lit_h, {name, " model_h"}, exp_h, lit_h);
    check(model_lat(cv, dv) == lit_lat, {name, " model_lat"}, model_lat(cv, dv), lit_lat);
  endtask

  // Next posedge is E0. Waits for done and checks latency; optionally drops
  // start at cycle drop_at, or pulses it low at toggle_at with new operands.
  task automatic wait_done(input int lat, input int drop_at, input int toggle_at,
                           input string name);
    int n;
    bit got;
    n = 0;
    got = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (done) got = 1;
      else check(busy == 1'b1, {name, " busy"}, busy, 1);
      if (n == drop_at) start = 1'b0;
      if (n == toggle_at) start = 1'b0;
      if (toggle_at > 0 && n == toggle_at + 1) begin
        start = 1'b1;
        a = 16'hFFFF; b = 16'hFFFF; c = 16'd2; d = 16'd7;
      end
    end
    check(got, {name, " done_timeout"}, got, 1);
    if (got) check(n - 1 == lat, {name, " latency"}, n - 1, lat);
  endtask

  task automatic release_start(input string name);
    start = 1'b0;
    @(negedge clk);
    check(done == 1'b0, {name, " done_fall"}, done, 0);
    check(busy == 1'b0, {name, " idle_busy"}, busy, 0);
  endtask

  initial begin
    logic [W-1:0] old_g, old_h;
    rst = 1'b1;
    start = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    @(negedge clk);
    @(negedge clk);
    check(g == 16'h0, "reset_g", g, 0);
    check(h == 16'h0, "reset_h", h, 0);
    check(done == 1'b0, "reset_done", done, 0);
    check(busy == 1'b0, "reset_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: popcount 16+1, log2(1000) = 9
    launch(16'hFFFF, 16'h0001, 16'd2, 16'd1000, 17, 9, 26, "t1");
    wait_done(26, 0, 0, "t1");
    release_start("t1");

    // 2: d = 0 and sentinel base
    launch(16'h0, 16'h0, 16'd3, 16'd0, 0, 0, 17, "t2a");
    wait_done(17, 0, 0, "t2a");
    release_start("t2a");
    launch(16'h0, 16'h0, 16'd1, 16'd500, 0, 16'hFFFF, 17, "t2b");
    wait_done(17, 0, 0, "t2b");
    release_start("t2b");

    // 3: large arguments
    launch(16'h00FF, 16'h0F0F, 16'd3, 16'hFFFF, 16, 10, 27, "t3a");
    wait_done(27, 0, 0, "t3a");
    release_start("t3a");
    launch(16'h0007, 16'h0000, 16'd2, 16'hFFFF, 3, 15, 32, "t3b");
    wait_done(32, 0, 0, "t3b");
    release_start("t3b");
    launch(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32, 1, 18, "t3c");
    wait_done(18, 0, 0, "t3c");
    release_start("t3c");

    // 4: reset mid-POP with start held high, then restart on release
    launch(16'h1234, 16'h00FF, 16'd5, 16'd3125, 13, 5, 22, "t4");
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check(g == 16'h0, "t4 rst_g", g, 0);
    check(h == 16'h0, "t4 rst_h", h, 0);
    check(done == 1'b0, "t4 rst_done", done, 0);
    check(busy == 1'b0, "t4 rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_done(22, 0, 0, "t4");
    release_start("t4");

    // 5a: drop start during LOG -> done for exactly one cycle
    launch(16'hAAAA, 16'h5555, 16'd2, 16'hFFFF, 16, 15, 32, "t5a");
    wait_done(32, 20, 0, "t5a");
    @(negedge clk);
    check(done == 1'b0, "t5a one_cycle_done", done, 0);
    // 5b: start pulsed low/high in POP with new operands -> ignored
    launch(16'hF0F0, 16'h0F00, 16'd10, 16'd9999, 12, 3, 20, "t5b");
    wait_done(20, 0, 5, "t5b");
    release_start("t5b");

    // 6: done held while start high; values held in IDLE until next capture
    launch(16'h8001, 16'h0000, 16'd7, 16'd49, 2, 2, 19, "t6a");
    wait_done(19, 0, 0, "t6a");
    repeat (10) begin
      @(negedge clk);
      check(done == 1'b1, "t6a done_held", done, 1);
    end
    old_g = exp_g;
    old_h = exp_h;
    release_start("t6a");
    check(g == 16'd2, "t6 idle_g_held", g, 2);
    check(h == 16'd2, "t6 idle_h_held", h, 2);
    launch(16'h0003, 16'h0007, 16'd4, 16'd63, 5, 2, 19, "t6b");
    #1;
    check(g == old_g, "t6 pre_e0_g", g, old_g);
    check(h == old_h, "t6 pre_e0_h", h, old_h);
    wait_done(19, 0, 0, "t6b");
    release_start("t6b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
